// File: rtl/systolic_seq_pkg.sv
// Shared types and sizing helpers for the systolic array job sequencer.
package systolic_seq_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_DRAIN,
        ST_FLUSH,
        ST_COLLECT,
        ST_SHOW
    } seq_state_e;

    function automatic int num_macs_f(input int w, input int h);
        return w * h;
    endfunction

    function automatic int num_operands_f(input int w, input int h);
        return 2 * w * h;
    endfunction

    // Index width for a count of n items; a single item still needs one bit.
    function automatic int idx_width_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts cycles while enabled and flags the last cycle of each count_p-cycle window.
module dwell_timer
    import systolic_seq_pkg::*;
#(
    parameter int count_p = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int cnt_w = idx_width_f(count_p);

    logic [cnt_w-1:0] cnt_q;

    assign expire_o = en_i & (cnt_q == cnt_w'(count_p - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= expire_o ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Sequences one matrix job: forward operands, drain, flush, collect results, then show each on the display.
module systolic_sequencer
    import systolic_seq_pkg::*;
#(
    parameter int width_p        = 8,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2,
    parameter int dwell_cycles_p = 60_000_000
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                in_valid_i,
    input  logic [width_p-1:0]  in_data_i,
    output logic                in_ready_o,
    output logic                sa_valid_o,
    output logic [width_p-1:0]  sa_data_o,
    input  logic                sa_ready_i,
    input  logic                sa_busy_i,
    output logic                sa_flush_o,
    input  logic                sa_valid_i,
    input  logic [width_p-1:0]  sa_data_i,
    output logic                sa_yumi_o,
    input  logic                abort_i,
    input  logic                advance_i,
    output logic                disp_valid_o,
    output logic [width_p-1:0]  disp_data_o,
    output logic [idx_width_f(num_macs_f(array_width_p, array_height_p))-1:0] disp_index_o,
    output logic                done_o
);

    localparam int num_macs     = num_macs_f(array_width_p, array_height_p);
    localparam int num_operands = num_operands_f(array_width_p, array_height_p);
    localparam int idx_w        = idx_width_f(num_macs);
    localparam int op_w         = idx_width_f(num_operands);

    seq_state_e       state_q, state_d;
    logic [op_w-1:0]  op_cnt_q;
    logic [idx_w-1:0] wr_idx_q, rd_idx_q;
    logic             done_q;
    logic [width_p-1:0] result_buf [num_macs];

    logic load_hs, collect_hs, show_advance;
    logic last_operand, last_result, last_shown;
    logic dwell_expire;

    dwell_timer #(
        .count_p (dwell_cycles_p)
    ) u_dwell (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  ((state_q != ST_SHOW) | advance_i | abort_i),
        .en_i     (state_q == ST_SHOW),
        .expire_o (dwell_expire)
    );

    always_comb begin
        load_hs      = (state_q == ST_LOAD) & in_valid_i & sa_ready_i & ~abort_i & ~reset_i;
        collect_hs   = (state_q == ST_COLLECT) & sa_valid_i & ~abort_i;
        show_advance = (state_q == ST_SHOW) & (advance_i | dwell_expire);
        last_operand = load_hs & (op_cnt_q == op_w'(num_operands - 1));
        last_result  = collect_hs & (wr_idx_q == idx_w'(num_macs - 1));
        last_shown   = show_advance & (rd_idx_q == idx_w'(num_macs - 1));

        state_d = state_q;
        unique case (state_q)
            ST_LOAD:    if (last_operand) state_d = ST_DRAIN;
            ST_DRAIN:   if (!sa_busy_i) state_d = ST_FLUSH;
            ST_FLUSH:   state_d = ST_COLLECT;
            ST_COLLECT: if (last_result) state_d = ST_SHOW;
            ST_SHOW:    if (last_shown) state_d = ST_LOAD;
            default:    state_d = ST_LOAD;
        endcase
        if (abort_i) state_d = ST_LOAD;

        // Operand path is a pure pass-through; an abort cycle accepts nothing.
        in_ready_o   = 1'b0;
        sa_valid_o   = 1'b0;
        sa_data_o    = '0;
        sa_flush_o   = ~reset_i & (abort_i | (state_q == ST_FLUSH));
        sa_yumi_o    = collect_hs;
        disp_valid_o = 1'b0;
        disp_data_o  = '0;
        disp_index_o = '0;
        done_o       = done_q;
        if (state_q == ST_LOAD && !reset_i && !abort_i) begin
            in_ready_o = sa_ready_i;
            sa_valid_o = in_valid_i;
            sa_data_o  = in_data_i;
        end
        if (state_q == ST_SHOW) begin
            disp_valid_o = 1'b1;
            disp_data_o  = result_buf[rd_idx_q];
            disp_index_o = rd_idx_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_LOAD;
            op_cnt_q <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= last_shown & ~abort_i;
            if (abort_i) begin
                op_cnt_q <= '0;
                wr_idx_q <= '0;
                rd_idx_q <= '0;
            end else begin
                if (last_operand)      op_cnt_q <= '0;
                else if (load_hs)      op_cnt_q <= op_cnt_q + 1'b1;
                if (last_result)       wr_idx_q <= '0;
                else if (collect_hs)   wr_idx_q <= wr_idx_q + 1'b1;
                if (last_shown)        rd_idx_q <= '0;
                else if (show_advance) rd_idx_q <= rd_idx_q + 1'b1;
            end
        end
    end

    // Result storage is data only and is never reset.
    always_ff @(posedge clk_i) begin
        if (collect_hs) result_buf[wr_idx_q] <= sa_data_i;
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Scoreboard bench for systolic_sequencer with a 2x2 array and a short dwell.
module tb_systolic_sequencer;

    localparam int W  = 8;
    localparam int NM = 4;
    localparam int NO = 8;
    localparam int DW = 4;

    logic         clk = 1'b0;
    logic         reset_i, in_valid_i, sa_ready_i, sa_busy_i, sa_valid_i, abort_i, advance_i;
    logic [W-1:0] in_data_i, sa_data_i;
    logic         in_ready_o, sa_valid_o, sa_flush_o, sa_yumi_o, disp_valid_o, done_o;
    logic [W-1:0] sa_data_o, disp_data_o;
    logic [1:0]   disp_index_o;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_ops[$];
    logic [W-1:0] exp_disp[$];

    always #5 clk = ~clk;

    systolic_sequencer #(
        .width_p(W), .array_width_p(2), .array_height_p(2), .dwell_cycles_p(DW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .sa_valid_o(sa_valid_o), .sa_data_o(sa_data_o), .sa_ready_i(sa_ready_i),
        .sa_busy_i(sa_busy_i), .sa_flush_o(sa_flush_o),
        .sa_valid_i(sa_valid_i), .sa_data_i(sa_data_i), .sa_yumi_o(sa_yumi_o),
        .abort_i(abort_i), .advance_i(advance_i),
        .disp_valid_o(disp_valid_o), .disp_data_o(disp_data_o),
        .disp_index_o(disp_index_o), .done_o(done_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input bit alt, input int n, input logic [W-1:0] base);
        int hs = 0;
        int cyc = 0;
        logic [W-1:0] exp;
        for (int i = 0; i < n; i++) exp_ops.push_back(base + W'(i));
        while (hs < n && cyc < 40) begin
            in_valid_i = 1'b1;
            in_data_i  = base + W'(hs);
            sa_ready_i = alt ? ((cyc % 2) == 0) : 1'b1;
            @(negedge clk);
            total++;
            if (in_ready_o !== sa_ready_i) begin
                bad++; $display("FAIL load_ready cyc=%0d got=%b exp=%b", cyc, in_ready_o, sa_ready_i);
            end
            total++;
            if (sa_valid_o !== 1'b1) begin
                bad++; $display("FAIL load_valid cyc=%0d got=%b exp=1", cyc, sa_valid_o);
            end
            if (sa_valid_o === 1'b1 && sa_ready_i === 1'b1) begin
                exp = (exp_ops.size() > 0) ? exp_ops.pop_front() : 'x;
                total++;
                if (sa_data_o !== exp) begin
                    bad++; $display("FAIL load_data got=%h exp=%h", sa_data_o, exp);
                end
                hs++;
            end
            tick();
            cyc++;
        end
        in_valid_i = 1'b0;
        sa_ready_i = 1'b1;
        total++;
        if (hs != n) begin
            bad++; $display("FAIL load_count got=%0d exp=%0d", hs, n);
        end
    endtask

    task automatic do_drain(input int busy_n);
        in_valid_i = 1'b1;
        sa_ready_i = 1'b1;
        sa_valid_i = 1'b1;
        sa_data_i  = 8'hEE;
        for (int c = 0; c <= busy_n; c++) begin
            sa_busy_i = (c < busy_n);
            @(negedge clk);
            total++;
            if ({in_ready_o, sa_valid_o, sa_flush_o, sa_yumi_o} !== 4'b0000) begin
                bad++; $display("FAIL drain c=%0d got rdy/vld/flush/yumi=%b exp=0000", c,
                                {in_ready_o, sa_valid_o, sa_flush_o, sa_yumi_o});
            end
            tick();
        end
        in_valid_i = 1'b0;
        sa_busy_i  = 1'b0;
        @(negedge clk);
        total++;
        if ({sa_flush_o, sa_yumi_o} !== 2'b10) begin
            bad++; $display("FAIL flush got flush/yumi=%b exp=10", {sa_flush_o, sa_yumi_o});
        end
        tick();
    endtask

    task automatic do_collect(input logic [W-1:0] base);
        int k = 0;
        int cyc = 0;
        while (k < NM && cyc < 20) begin
            sa_valid_i = (cyc != 1);
            sa_data_i  = base + W'(17 * (k + 1));
            @(negedge clk);
            total++;
            if (sa_yumi_o !== sa_valid_i || sa_flush_o !== 1'b0) begin
                bad++; $display("FAIL collect cyc=%0d got yumi=%b flush=%b exp yumi=%b flush=0",
                                cyc, sa_yumi_o, sa_flush_o, sa_valid_i);
            end
            if (sa_valid_i && sa_yumi_o === 1'b1) begin
                exp_disp.push_back(sa_data_i);
                k++;
            end
            tick();
            cyc++;
        end
        sa_valid_i = 1'b0;
        total++;
        if (k != NM) begin
            bad++; $display("FAIL collect_count got=%0d exp=%0d", k, NM);
        end
    endtask

    task automatic do_show(input bit adv, input int per);
        logic [W-1:0] exp;
        for (int i = 0; i < NM; i++) begin
            exp = (exp_disp.size() > 0) ? exp_disp.pop_front() : 'x;
            for (int c = 0; c < per; c++) begin
                advance_i = adv && (c == 1);
                @(negedge clk);
                total++;
                if (disp_valid_o !== 1'b1 || disp_data_o !== exp || disp_index_o !== 2'(i) || done_o !== 1'b0) begin
                    bad++; $display("FAIL show i=%0d c=%0d got v=%b d=%h idx=%0d done=%b exp v=1 d=%h idx=%0d done=0",
                                    i, c, disp_valid_o, disp_data_o, disp_index_o, done_o, exp, i);
                end
                tick();
            end
        end
        advance_i  = 1'b0;
        in_valid_i = 1'b0;
        sa_ready_i = 1'b1;
        @(negedge clk);
        total++;
        if (done_o !== 1'b1 || disp_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
            bad++; $display("FAIL done_pulse got done=%b v=%b rdy=%b exp done=1 v=0 rdy=1",
                            done_o, disp_valid_o, in_ready_o);
        end
        tick();
        @(negedge clk);
        total++;
        if (done_o !== 1'b0) begin
            bad++; $display("FAIL done_once got=%b exp=0", done_o);
        end
        tick();
    endtask

    task automatic test_reset();
        reset_i = 1'b1; in_valid_i = 1'b1; sa_ready_i = 1'b1; sa_valid_i = 1'b1;
        tick();
        tick();
        @(negedge clk);
        total++;
        if (in_ready_o !== 1'b0 || sa_valid_o !== 1'b0) begin
            bad++; $display("FAIL reset_forced got rdy=%b vld=%b exp 0 0", in_ready_o, sa_valid_o);
        end
        tick();
        reset_i = 1'b0; in_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if ({disp_valid_o, sa_flush_o, sa_yumi_o, done_o} !== 4'b0000 || disp_data_o !== 8'h00 || disp_index_o !== 2'd0) begin
            bad++; $display("FAIL reset_outputs got v/fl/yumi/done=%b d=%h idx=%0d exp 0000 00 0",
                            {disp_valid_o, sa_flush_o, sa_yumi_o, done_o}, disp_data_o, disp_index_o);
        end
        total++;
        if (in_ready_o !== 1'b1) begin
            bad++; $display("FAIL reset_load_ready got=%b exp=1", in_ready_o);
        end
        tick();
        sa_valid_i = 1'b0;
    endtask

    task automatic test_basic();
        do_load(1'b0, NO, 8'h01);
        do_drain(0);
        do_collect(8'h00);
        do_show(1'b0, DW);
    endtask

    task automatic test_ready_toggle();
        do_load(1'b1, NO, 8'h21);
        do_drain(0);
        do_collect(8'h03);
        do_show(1'b0, DW);
    endtask

    task automatic test_busy_hold();
        do_load(1'b0, NO, 8'h31);
        do_drain(20);
        do_collect(8'h07);
        do_show(1'b0, DW);
    endtask

    task automatic test_advance();
        do_load(1'b0, NO, 8'h51);
        do_drain(0);
        do_collect(8'h09);
        do_show(1'b1, 2);
    endtask

    task automatic test_abort();
        do_load(1'b0, 5, 8'h41);
        abort_i = 1'b1;
        @(negedge clk);
        total++;
        if (sa_flush_o !== 1'b1) begin
            bad++; $display("FAIL abort_flush got=%b exp=1", sa_flush_o);
        end
        tick();
        abort_i = 1'b0;
        @(negedge clk);
        total++;
        if (sa_flush_o !== 1'b0 || done_o !== 1'b0 || in_ready_o !== 1'b1) begin
            bad++; $display("FAIL abort_after got flush=%b done=%b rdy=%b exp 0 0 1", sa_flush_o, done_o, in_ready_o);
        end
        tick();
        do_load(1'b0, NO, 8'h81);
        do_drain(0);
        do_collect(8'h0B);
        do_show(1'b0, DW);
    endtask

    task automatic test_reset_mid_show();
        do_load(1'b0, NO, 8'h91);
        do_drain(0);
        do_collect(8'h05);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (disp_valid_o !== 1'b1) begin
                bad++; $display("FAIL midshow_valid got=%b exp=1", disp_valid_o);
            end
            tick();
        end
        reset_i = 1'b1; in_valid_i = 1'b1; sa_ready_i = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready_o !== 1'b0 || sa_valid_o !== 1'b0) begin
            bad++; $display("FAIL rst_held got rdy=%b vld=%b exp 0 0", in_ready_o, sa_valid_o);
        end
        tick();
        @(negedge clk);
        total++;
        if (disp_valid_o !== 1'b0 || in_ready_o !== 1'b0) begin
            bad++; $display("FAIL rst_show got v=%b rdy=%b exp 0 0", disp_valid_o, in_ready_o);
        end
        tick();
        reset_i = 1'b0; in_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if (disp_valid_o !== 1'b0 || in_ready_o !== 1'b1 || done_o !== 1'b0) begin
            bad++; $display("FAIL rst_release got v=%b rdy=%b done=%b exp 0 1 0", disp_valid_o, in_ready_o, done_o);
        end
        tick();
        exp_disp.delete();
    endtask

    initial begin
        reset_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; sa_ready_i = 1'b0; sa_busy_i = 1'b0;
        sa_valid_i = 1'b0; sa_data_i = '0; abort_i = 1'b0; advance_i = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_ready_toggle();
        test_busy_hold();
        test_advance();
        test_abort();
        test_reset_mid_show();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
